button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//   Conditions a raw, asynchronous push-button for the manual single-step clock
//   stage. Synchronises and debounces the input, then emits a clean level
//   (drives manual_clock.button) plus one-cycle press/release/repeat pulses.
//   Hold-to-repeat lets an operator free-run the CPU step by step.
// PARAMETERS
//   SYNC_STAGES    2        synchroniser flops on button_raw (>=2)
//   DEBOUNCE_CYCLES 1000000 consecutive stable samples to accept a change (>=2)
//   REPEAT_EN      1        1 = hold-to-repeat enabled, 0 = never leave PRESSED
//   REPEAT_DELAY   50000000 cycles held in PRESSED before first repeat (>=1)
//   REPEAT_PERIOD  10000000 cycles between repeat pulses in REPEAT (>=1)
//   CNT_W          26       counter width; must hold max of the three counts
// PORTS
//   clock          in   1  system clock
//   reset          in   1  asynchronous, active-high reset
//   button_raw     in   1  raw pad input, asynchronous, bouncy
//   level          out  1  debounced button level
//   press_pulse    out  1  1-cycle pulse on accepted press
//   release_pulse  out  1  1-cycle pulse on accepted release
//   repeat_pulse   out  1  1-cycle pulse per auto-repeat tick
//   held_long      out  1  high while in REPEAT (incl. its release debounce)
// BEHAVIOUR
//   Reset: reset is asynchronous, active-high; clock is clock. Sync flops=0,
//   state=IDLE, counters=0, all outputs=0. Reset dominates every other event.
//   btn_s = last synchroniser stage; FSM samples only btn_s, never button_raw.
//   States (all outputs registered):
//   IDLE:         btn_s=1 -> PRESS_WAIT, cnt=1; else stay.
//   PRESS_WAIT:   btn_s=0 -> IDLE (glitch dropped, no pulse).
//                 btn_s=1 & cnt==DEBOUNCE_CYCLES-1 -> PRESSED, level=1,
//                 press_pulse=1, hold_cnt=0; else cnt++.
//   PRESSED:      btn_s=0 -> RELEASE_WAIT, cnt=1.
//                 REPEAT_EN & hold_cnt==REPEAT_DELAY-1 -> REPEAT,
//                 repeat_pulse=1, held_long=1, rep_cnt=0; else hold_cnt++.
//   REPEAT:       btn_s=0 -> RELEASE_WAIT, cnt=1.
//                 rep_cnt==REPEAT_PERIOD-1 -> repeat_pulse=1, rep_cnt=0;
//                 else rep_cnt++.
//   RELEASE_WAIT: btn_s=1 -> REPEAT if held_long (rep_cnt=0), else PRESSED
//                 (hold_cnt=0); level stays 1, no pulse.
//                 btn_s=0 & cnt==DEBOUNCE_CYCLES-1 -> IDLE, level=0,
//                 release_pulse=1, held_long=0; else cnt++.
//   Latency: a clean raw edge between edges 0 and 1 changes level at edge
//   SYNC_STAGES+DEBOUNCE_CYCLES. Release latency is identical.
//   Pulses are exactly 1 cycle and never coincide with each other.
//   No repeat_pulse outside REPEAT, except the entry pulse on PRESSED->REPEAT.
//   Counters never wrap: each is cleared on state entry and compared with ==.
//   Reset mid-debounce or mid-repeat -> IDLE immediately, no release_pulse.
//   REPEAT_EN=0: PRESSED persists while held; repeat_pulse, held_long stay 0.
// TESTING (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//   1 Clean press at edge 0, held 8 cycles -> level=1 and press_pulse=1 at
//     edge 6; release -> level=0 and release_pulse=1 six edges later.
//   2 Bounce: raw 1,0,1,0 for 1 cycle each, then 0 -> level, all pulses stay 0.
//   3 Hold 30 cycles -> first repeat_pulse 10 cycles after press_pulse, then
//     every 3 cycles, held_long=1; release -> held_long=0 with release_pulse.
//   4 Release bounce (raw 0 for 2 cycles, then 1) in PRESSED -> level stays 1,
//     no release_pulse, returns to PRESSED; in REPEAT, returns to REPEAT.
//   5 Assert reset during PRESS_WAIT and during REPEAT -> all outputs 0
//     asynchronously; the next clean press behaves as in test 1.
//   6 REPEAT_EN=0, hold 40 cycles -> exactly one press_pulse, repeat_pulse=0.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button conditioner for the manual single-step clock stage.
// Synchronises the raw pad input, debounces press and release, and produces a
// clean level plus one-cycle press / release / auto-repeat pulses.
module button_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic clock,
    input  logic reset,
    input  logic button_raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic held_long
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_PRESSED,
        S_REPEAT,
        S_RELEASE_WAIT
    } state_t;

    // Terminal counts; counters are cleared on state entry and compared with ==
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   btn_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]       rep_cnt_q, rep_cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   repeat_q, repeat_d;
    logic                   held_q, held_d;

    // The FSM only ever looks at the last synchroniser stage
    assign btn_s = sync_q[SYNC_STAGES-1];

    // Synchroniser shift: raw pad enters at bit 0
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], button_raw};
    end

    // State register: all flops, asynchronously cleared by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            repeat_q   <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            repeat_q   <= repeat_d;
            held_q     <= held_d;
        end
    end

    // Next-state and counter logic; a released button always wins over counting
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (btn_s) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            S_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d    = S_PRESSED;
                    hold_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_PRESSED: begin
                if (!btn_s) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else if ((REPEAT_EN != 0) && (hold_cnt_q == HOLD_LAST)) begin
                    state_d   = S_REPEAT;
                    rep_cnt_d = '0;
                end else if (REPEAT_EN != 0) begin
                    // Without repeat the hold counter is frozen so it can never wrap
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
            end
            S_REPEAT: begin
                if (!btn_s) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else if (rep_cnt_q == REP_LAST) begin
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + CNT_ONE;
                end
            end
            S_RELEASE_WAIT: begin
                if (btn_s) begin
                    // Release bounce: resume whichever held state we came from
                    if (held_q) begin
                        state_d   = S_REPEAT;
                        rep_cnt_d = '0;
                    end else begin
                        state_d    = S_PRESSED;
                        hold_cnt_d = '0;
                    end
                end else if (cnt_q == DEB_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: registered outputs derived from the transition being taken
    always_comb begin
        level_d   = (state_d == S_PRESSED) || (state_d == S_REPEAT) ||
                    (state_d == S_RELEASE_WAIT);
        press_d   = (state_q == S_PRESS_WAIT) && (state_d == S_PRESSED);
        release_d = (state_q == S_RELEASE_WAIT) && (state_d == S_IDLE);
        repeat_d  = ((state_q == S_PRESSED) && (state_d == S_REPEAT)) ||
                    ((state_q == S_REPEAT) && btn_s && (rep_cnt_q == REP_LAST));
        // held_long survives a release debounce that started from REPEAT
        held_d    = (state_d == S_REPEAT) ||
                    ((state_d == S_RELEASE_WAIT) && held_q);
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    assign held_long     = held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus queues expected pulse
// events (kind, edge number, level, held_long); monitors pop and compare
// whenever the DUT raises any pulse.
module tb_button_conditioner;

    localparam logic [2:0] K_PRESS = 3'b001;
    localparam logic [2:0] K_REL   = 3'b010;
    localparam logic [2:0] K_REP   = 3'b100;

    typedef struct {
        logic [2:0] pv;
        int         edge_n;
        logic       lvl;
        logic       hl;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic raw1  = 1'b0;
    logic raw0  = 1'b0;
    logic level1, press1, release1, repeat1, held1;
    logic level0, press0, release0, repeat0, held0;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic rep0_seen = 1'b0;
    ev_t  q1[$];
    ev_t  q0[$];
    ev_t  ev1, ev0;
    int   e;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    button_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .CNT_W(8)
    ) dut1 (
        .clock(clock), .reset(reset), .button_raw(raw1),
        .level(level1), .press_pulse(press1), .release_pulse(release1),
        .repeat_pulse(repeat1), .held_long(held1)
    );

    button_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .CNT_W(8)
    ) dut0 (
        .clock(clock), .reset(reset), .button_raw(raw0),
        .level(level0), .press_pulse(press0), .release_pulse(release0),
        .repeat_pulse(repeat0), .held_long(held0)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push1(input logic [2:0] pv, input int edge_n, input logic lvl, input logic hl);
        ev_t ev;
        ev.pv = pv; ev.edge_n = edge_n; ev.lvl = lvl; ev.hl = hl;
        q1.push_back(ev);
    endtask

    task automatic push0(input logic [2:0] pv, input int edge_n, input logic lvl, input logic hl);
        ev_t ev;
        ev.pv = pv; ev.edge_n = edge_n; ev.lvl = lvl; ev.hl = hl;
        q0.push_back(ev);
    endtask

    // Monitor for the repeat-enabled DUT
    always @(negedge clock) begin
        if ({repeat1, release1, press1} != 3'b000) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut1_unexpected: got pulses %b expected none (cycle %0d)",
                         {repeat1, release1, press1}, cyc);
            end else begin
                ev1 = q1.pop_front();
                $display("dut1 event pulses=%b edge=%0d level=%b held_long=%b",
                         {repeat1, release1, press1}, cyc, level1, held1);
                check("dut1_kind", int'({repeat1, release1, press1}), int'(ev1.pv));
                check("dut1_edge", cyc, ev1.edge_n);
                check("dut1_level", int'(level1), int'(ev1.lvl));
                check("dut1_held_long", int'(held1), int'(ev1.hl));
            end
        end
    end

    // Monitor for the repeat-disabled DUT
    always @(negedge clock) begin
        if (repeat0 || held0) rep0_seen = 1'b1;
        if ({repeat0, release0, press0} != 3'b000) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut0_unexpected: got pulses %b expected none (cycle %0d)",
                         {repeat0, release0, press0}, cyc);
            end else begin
                ev0 = q0.pop_front();
                $display("dut0 event pulses=%b edge=%0d level=%b held_long=%b",
                         {repeat0, release0, press0}, cyc, level0, held0);
                check("dut0_kind", int'({repeat0, release0, press0}), int'(ev0.pv));
                check("dut0_edge", cyc, ev0.edge_n);
                check("dut0_level", int'(level0), int'(ev0.lvl));
            end
        end
    end

    initial begin
        // Reset state
        tick(2);
        check("reset_outputs_dut1", int'({level1, press1, release1, repeat1, held1}), 0);
        check("reset_outputs_dut0", int'({level0, press0, release0, repeat0, held0}), 0);
        reset = 1'b0;
        tick(3);
        check("idle_outputs_dut1", int'({level1, press1, release1, repeat1, held1}), 0);

        // 1: clean press, held 8 cycles
        e = cyc; raw1 = 1'b1;
        push1(K_PRESS, e + 6, 1'b1, 1'b0);
        push1(K_REL, e + 14, 1'b0, 1'b0);
        tick(8); raw1 = 1'b0;
        tick(10);

        // 2: bounce 1,0,1,0 then 0 - nothing accepted
        raw1 = 1'b1; tick(1); raw1 = 1'b0; tick(1);
        raw1 = 1'b1; tick(1); raw1 = 1'b0; tick(12);
        check("bounce_level", int'(level1), 0);

        // 3: hold 30 cycles with auto-repeat
        e = cyc; raw1 = 1'b1;
        push1(K_PRESS, e + 6, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) push1(K_REP, e + 16 + 3 * k, 1'b1, 1'b1);
        push1(K_REL, e + 36, 1'b0, 1'b0);
        tick(20);
        check("hold_held_long", int'(held1), 1);
        tick(10); raw1 = 1'b0;
        tick(12);
        check("after_hold_held_long", int'(held1), 0);

        // 4a: release bounce while PRESSED
        e = cyc; raw1 = 1'b1;
        push1(K_PRESS, e + 6, 1'b1, 1'b0);
        push1(K_REL, e + 20, 1'b0, 1'b0);
        tick(8); raw1 = 1'b0;
        tick(2); raw1 = 1'b1;
        tick(3);
        check("relbounce_pressed_level", int'(level1), 1);
        tick(1); raw1 = 1'b0;
        tick(12);

        // 4b: release bounce while in REPEAT
        e = cyc; raw1 = 1'b1;
        push1(K_PRESS, e + 6, 1'b1, 1'b0);
        push1(K_REP, e + 16, 1'b1, 1'b1);
        push1(K_REP, e + 19, 1'b1, 1'b1);
        push1(K_REP, e + 27, 1'b1, 1'b1);
        push1(K_REP, e + 30, 1'b1, 1'b1);
        push1(K_REL, e + 34, 1'b0, 1'b0);
        tick(19); raw1 = 1'b0;
        tick(2); raw1 = 1'b1;
        tick(2);
        check("relbounce_repeat_lvl_held", int'({level1, held1}), 3);
        tick(5); raw1 = 1'b0;
        tick(12);

        // 5a: reset during PRESS_WAIT
        raw1 = 1'b1;
        tick(4);
        reset = 1'b1; raw1 = 1'b0;
        #1;
        check("reset_presswait_outputs", int'({level1, press1, release1, repeat1, held1}), 0);
        tick(2); reset = 1'b0;
        tick(8);
        check("after_reset_pw_level", int'(level1), 0);

        // 5b: reset during REPEAT drops level and held_long without a clock edge
        e = cyc; raw1 = 1'b1;
        push1(K_PRESS, e + 6, 1'b1, 1'b0);
        push1(K_REP, e + 16, 1'b1, 1'b1);
        tick(18);
        check("pre_reset_lvl_held", int'({level1, held1}), 3);
        reset = 1'b1; raw1 = 1'b0;
        #1;
        check("reset_repeat_outputs", int'({level1, press1, release1, repeat1, held1}), 0);
        tick(2); reset = 1'b0;
        tick(4);
        e = cyc; raw1 = 1'b1;
        push1(K_PRESS, e + 6, 1'b1, 1'b0);
        push1(K_REL, e + 14, 1'b0, 1'b0);
        tick(8); raw1 = 1'b0;
        tick(10);

        // 6: REPEAT_EN=0, hold 40 cycles
        e = cyc; raw0 = 1'b1;
        push0(K_PRESS, e + 6, 1'b1, 1'b0);
        push0(K_REL, e + 46, 1'b0, 1'b0);
        tick(40);
        check("norepeat_level", int'(level0), 1);
        raw0 = 1'b0;
        tick(12);

        // Every queued event must have been seen; dut0 never repeats
        check("dut1_events_pending", q1.size(), 0);
        check("dut0_events_pending", q0.size(), 0);
        check("dut0_repeat_or_held_seen", int'(rep0_seen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
